// File: rtl/branch_resolve_queue_if.sv
// Bundle of fetch-push, execute-resolve and predictor/fetch feedback signals
// for the branch resolve queue. The slave side is the queue itself.
interface branch_resolve_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            pred_valid;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic [XLEN-1:0] pred_fallthru;
  logic            pred_ready;
  logic            resolve_valid;
  logic            resolve_taken;
  logic            upd_valid;
  logic            upd_outcome;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   count;
  logic [15:0]     mispredict_cnt;
  logic            underflow;

  modport master (
    output pred_valid, pred_taken, pred_target, pred_fallthru,
    output resolve_valid, resolve_taken,
    input  pred_ready, upd_valid, upd_outcome, flush, redirect_pc,
    input  count, mispredict_cnt, underflow
  );

  modport slave (
    input  pred_valid, pred_taken, pred_target, pred_fallthru,
    input  resolve_valid, resolve_taken,
    output pred_ready, upd_valid, upd_outcome, flush, redirect_pc,
    output count, mispredict_cnt, underflow
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; resolves the oldest against execute,
// updates the predictor and flushes/redirects fetch on a mispredict.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  branch_resolve_queue_if.slave  io_brq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic            r_taken    [DEPTH];
  logic [XLEN-1:0] r_target   [DEPTH];
  logic [XLEN-1:0] r_fallthru [DEPTH];

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            r_upd_valid;
  logic            r_upd_outcome;
  logic            r_flush;
  logic [XLEN-1:0] r_redirect_pc;
  logic [15:0]     r_mispredict_cnt;
  logic            r_underflow;

  logic            w_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_mispredict;
  logic            w_underflow;
  logic [XLEN-1:0] w_correct_pc;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and push/pop decode; RECOVER ignores both request inputs
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_mispredict = 1'b0;
    w_underflow  = 1'b0;
    w_correct_pc = io_brq.resolve_taken ? r_target[r_rd_ptr] : r_fallthru[r_rd_ptr];
    case (r_state)
      RUN: begin
        w_ready      = (r_count < CW'(DEPTH));
        w_pop        = io_brq.resolve_valid && (r_count != {CW{1'b0}});
        w_underflow  = io_brq.resolve_valid && (r_count == {CW{1'b0}});
        w_mispredict = w_pop && (r_taken[r_rd_ptr] != io_brq.resolve_taken);
        // a push alongside a mispredict is wrong-path and is discarded
        w_push       = io_brq.pred_valid && w_ready && !w_mispredict;
        if (w_mispredict) begin
          w_next_state = RECOVER;
        end else begin
          w_next_state = RUN;
        end
      end
      RECOVER: begin
        w_next_state = RUN;
      end
      default: begin
        w_next_state = RUN;
      end
    endcase
  end

  // Entry storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_taken[r_wr_ptr]    <= io_brq.pred_taken;
      r_target[r_wr_ptr]   <= io_brq.pred_target;
      r_fallthru[r_wr_ptr] <= io_brq.pred_fallthru;
    end
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (w_mispredict) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered predictor update, flush/redirect and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_upd_valid      <= 1'b0;
      r_upd_outcome    <= 1'b0;
      r_flush          <= 1'b0;
      r_redirect_pc    <= {XLEN{1'b0}};
      r_mispredict_cnt <= 16'h0000;
      r_underflow      <= 1'b0;
    end else begin
      r_upd_valid   <= w_pop;
      r_upd_outcome <= w_pop ? io_brq.resolve_taken : 1'b0;
      r_flush       <= w_mispredict;
      r_underflow   <= w_underflow;
      if (w_mispredict) begin
        r_redirect_pc <= w_correct_pc;
        if (r_mispredict_cnt != 16'hFFFF) begin
          r_mispredict_cnt <= r_mispredict_cnt + 16'h0001;
        end
      end
    end
  end

  assign io_brq.pred_ready     = w_ready;
  assign io_brq.count          = r_count;
  assign io_brq.upd_valid      = r_upd_valid;
  assign io_brq.upd_outcome    = r_upd_outcome;
  assign io_brq.flush          = r_flush;
  assign io_brq.redirect_pc    = r_redirect_pc;
  assign io_brq.mispredict_cnt = r_mispredict_cnt;
  assign io_brq.underflow      = r_underflow;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed, table-driven bench for branch_resolve_queue plus hand-written
// sequences for pointer wrap with FIFO ordering and reset during recovery.
module tb_branch_resolve_queue;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  branch_resolve_queue_if #(.DEPTH(4), .XLEN(32)) brq_if ();

  branch_resolve_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io_brq  (brq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic        pt;
    logic [31:0] tgt;
    logic [31:0] ft;
    logic        rv;
    logic        rt;
    logic        e_ready;
    logic [2:0]  e_count;
    logic        e_upd;
    logic        e_out;
    logic        e_flush;
    logic [31:0] e_redir;
    logic [15:0] e_mcnt;
    logic        e_uf;
  } vec_t;

  vec_t vecs[$];

  typedef struct {
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] ft;
  } ent_t;

  ent_t model_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic pv, input logic pt, input logic [31:0] tgt, input logic [31:0] ft,
                     input logic rv, input logic rt, input logic e_ready, input logic [2:0] e_count,
                     input logic e_upd, input logic e_out, input logic e_flush,
                     input logic [31:0] e_redir, input logic [15:0] e_mcnt, input logic e_uf);
    vec_t v;
    v.pv = pv; v.pt = pt; v.tgt = tgt; v.ft = ft; v.rv = rv; v.rt = rt;
    v.e_ready = e_ready; v.e_count = e_count; v.e_upd = e_upd; v.e_out = e_out;
    v.e_flush = e_flush; v.e_redir = e_redir; v.e_mcnt = e_mcnt; v.e_uf = e_uf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic pv, input logic pt, input logic [31:0] tgt, input logic [31:0] ft,
                       input logic rv, input logic rt);
    brq_if.pred_valid    = pv;
    brq_if.pred_taken    = pt;
    brq_if.pred_target   = tgt;
    brq_if.pred_fallthru = ft;
    brq_if.resolve_valid = rv;
    brq_if.resolve_taken = rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] pat;
    ent_t        e;
    logic        rt;
    logic [31:0] exp_pc;

    checks = 0;
    errors = 0;
    pat    = 12'b1011_0011_1010;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // hand-computed vectors; each row's expectations are sampled after one edge
    add(1'b1, 1'b1, 32'h100, 32'h04, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'h0,   16'd0, 1'b0);
    add(1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 32'h0,   16'd0, 1'b0);
    add(1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0,   16'd0, 1'b0);
    add(1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0,   16'd0, 1'b1);
    add(1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0,   16'd0, 1'b0);
    add(1'b1, 1'b0, 32'h200, 32'h08, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'h0,   16'd0, 1'b0);
    add(1'b1, 1'b1, 32'h300, 32'h0C, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 32'h0,   16'd0, 1'b0);
    add(1'b1, 1'b0, 32'h400, 32'h10, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 32'h0,   16'd0, 1'b0);
    add(1'b1, 1'b1, 32'h500, 32'h14, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 32'h0,   16'd0, 1'b0);
    add(1'b1, 1'b0, 32'h600, 32'h18, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 32'h0,   16'd0, 1'b0);
    add(1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 32'h0,   16'd0, 1'b0);
    add(1'b1, 1'b1, 32'h700, 32'h1C, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 32'h0,   16'd0, 1'b0);
    add(1'b1, 1'b0, 32'h800, 32'h20, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 32'h400, 16'd1, 1'b0);
    add(1'b1, 1'b1, 32'h900, 32'h24, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h400, 16'd1, 1'b0);
    add(1'b1, 1'b0, 32'h200, 32'h08, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'h400, 16'd1, 1'b0);
    add(1'b1, 1'b1, 32'h220, 32'h28, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 32'h400, 16'd1, 1'b0);
    add(1'b1, 1'b0, 32'h240, 32'h2C, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 32'h400, 16'd1, 1'b0);
    add(1'b1, 1'b1, 32'h260, 32'h30, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 32'h200, 16'd2, 1'b0);
    add(1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h200, 16'd2, 1'b0);

    #12;
    check("reset_ready", 32'(brq_if.pred_ready), 32'd1);
    check("reset_count", 32'(brq_if.count), 32'd0);
    check("reset_upd", 32'(brq_if.upd_valid), 32'd0);
    check("reset_flush", 32'(brq_if.flush), 32'd0);
    check("reset_redir", brq_if.redirect_pc, 32'd0);
    check("reset_mcnt", 32'(brq_if.mispredict_cnt), 32'd0);
    check("reset_uf", 32'(brq_if.underflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].pv, vecs[i].pt, vecs[i].tgt, vecs[i].ft, vecs[i].rv, vecs[i].rt);
      step();
      check($sformatf("v%0d_ready", i), 32'(brq_if.pred_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d_count", i), 32'(brq_if.count), 32'(vecs[i].e_count));
      check($sformatf("v%0d_upd", i), 32'(brq_if.upd_valid), 32'(vecs[i].e_upd));
      if (vecs[i].e_upd) begin
        check($sformatf("v%0d_outcome", i), 32'(brq_if.upd_outcome), 32'(vecs[i].e_out));
      end
      check($sformatf("v%0d_flush", i), 32'(brq_if.flush), 32'(vecs[i].e_flush));
      check($sformatf("v%0d_redir", i), brq_if.redirect_pc, vecs[i].e_redir);
      check($sformatf("v%0d_mcnt", i), 32'(brq_if.mispredict_cnt), 32'(vecs[i].e_mcnt));
      check($sformatf("v%0d_uf", i), 32'(brq_if.underflow), 32'(vecs[i].e_uf));
    end

    // pointer wrap: prime two entries, then ten push+correct-pop cycles
    for (int k = 0; k < 2; k++) begin
      e.taken = pat[k];
      e.tgt   = 32'h1000 + 32'(k) * 32'h10;
      e.ft    = 32'h2000 + 32'(k) * 32'h4;
      model_q.push_back(e);
      drive(1'b1, e.taken, e.tgt, e.ft, 1'b0, 1'b0);
      step();
    end
    check("wrap_prime_count", 32'(brq_if.count), 32'd2);
    for (int k = 2; k < 12; k++) begin
      e.taken = pat[k];
      e.tgt   = 32'h1000 + 32'(k) * 32'h10;
      e.ft    = 32'h2000 + 32'(k) * 32'h4;
      rt = model_q[0].taken;
      drive(1'b1, e.taken, e.tgt, e.ft, 1'b1, rt);
      void'(model_q.pop_front());
      model_q.push_back(e);
      step();
      check($sformatf("wrap%0d_count", k), 32'(brq_if.count), 32'd2);
      check($sformatf("wrap%0d_flush", k), 32'(brq_if.flush), 32'd0);
      check($sformatf("wrap%0d_upd", k), 32'(brq_if.upd_valid), 32'd1);
      check($sformatf("wrap%0d_outcome", k), 32'(brq_if.upd_outcome), 32'(rt));
    end

    // mispredict on the wrapped head, redirect chosen from the model entry
    rt     = ~model_q[0].taken;
    exp_pc = rt ? model_q[0].tgt : model_q[0].ft;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, rt);
    step();
    check("wrap_mp_flush", 32'(brq_if.flush), 32'd1);
    check("wrap_mp_redir", brq_if.redirect_pc, exp_pc);
    check("wrap_mp_mcnt", 32'(brq_if.mispredict_cnt), 32'd3);
    check("wrap_mp_count", 32'(brq_if.count), 32'd0);
    check("wrap_mp_ready", 32'(brq_if.pred_ready), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    check("wrap_post_flush", 32'(brq_if.flush), 32'd0);
    check("wrap_post_redir", brq_if.redirect_pc, exp_pc);

    // reset asserted while flush is high takes effect without a clock edge
    drive(1'b1, 1'b0, 32'h300, 32'h30, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("rcv_flush_pre", 32'(brq_if.flush), 32'd1);
    check("rcv_mcnt_pre", 32'(brq_if.mispredict_cnt), 32'd4);
    #1;
    reset_n = 1'b0;
    #1;
    check("rcv_flush_rst", 32'(brq_if.flush), 32'd0);
    check("rcv_count_rst", 32'(brq_if.count), 32'd0);
    check("rcv_mcnt_rst", 32'(brq_if.mispredict_cnt), 32'd0);
    check("rcv_redir_rst", brq_if.redirect_pc, 32'd0);
    check("rcv_ready_rst", 32'(brq_if.pred_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("rcv_after_flush", 32'(brq_if.flush), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
